// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold and tenure-limited preemption.
// All outputs are registered; gnt_id_o drives the downstream datapath mux select.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_id_o,
    output logic       gnt_valid_o,
    output logic       preempt_o,
    output logic [7:0] tenure_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ACT_IDLE    = 3'd0,
        ACT_START   = 3'd1,
        ACT_HANDOFF = 3'd2,
        ACT_PREEMPT = 3'd3,
        ACT_HOLD    = 3'd4
    } act_e;

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    // Returns {found, index} of the first set bit of vec searched from start upward, wrapping.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int off = 7; off >= 0; off--) begin
            idx = start + 3'(off);
            res = vec[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    state_e     state_q, state_d;
    act_e       act_s;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       preempt_q, preempt_d;
    logic [7:0] tenure_q, tenure_d;

    logic [7:0] others_s;
    logic [3:0] pick_idle_s;
    logic [3:0] pick_next_s;
    logic [2:0] next_ptr_s;

    // Masking via the one-hot grant excludes the holder; the search after a holder starts just past it.
    assign others_s    = req_i & ~gnt_q;
    assign next_ptr_s  = gnt_id_q + 3'd1;
    assign pick_idle_s = rr_pick(req_i, ptr_q);
    assign pick_next_s = rr_pick(others_s, next_ptr_s);

    // State and priority-pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state decision: release has priority over timeout, timeout over hold.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        act_s   = ACT_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_GRANT;
                    act_s   = ACT_START;
                end else begin
                    state_d = ST_IDLE;
                    act_s   = ACT_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req_i[gnt_id_q]) begin
                    ptr_d = next_ptr_s;
                    if (pick_next_s[3]) begin
                        state_d = ST_GRANT;
                        act_s   = ACT_HANDOFF;
                    end else begin
                        state_d = ST_IDLE;
                        act_s   = ACT_IDLE;
                    end
                end else if ((tenure_q == HOLD_MAX_C) && (|others_s)) begin
                    ptr_d   = next_ptr_s;
                    state_d = ST_GRANT;
                    act_s   = ACT_PREEMPT;
                end else begin
                    state_d = ST_GRANT;
                    act_s   = ACT_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 3'd0;
                act_s   = ACT_IDLE;
            end
        endcase
    end

    // Output next-values derived from the chosen action.
    always_comb begin
        gnt_d       = 8'h00;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
        preempt_d   = 1'b0;
        tenure_d    = 8'd0;
        case (act_s)
            ACT_IDLE: begin
                gnt_d       = 8'h00;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                tenure_d    = 8'd0;
            end
            ACT_START: begin
                gnt_d       = 8'h01 << pick_idle_s[2:0];
                gnt_id_d    = pick_idle_s[2:0];
                gnt_valid_d = 1'b1;
                tenure_d    = 8'd1;
            end
            ACT_HANDOFF, ACT_PREEMPT: begin
                gnt_d       = 8'h01 << pick_next_s[2:0];
                gnt_id_d    = pick_next_s[2:0];
                gnt_valid_d = 1'b1;
                preempt_d   = (act_s == ACT_PREEMPT);
                tenure_d    = 8'd1;
            end
            ACT_HOLD: begin
                gnt_d       = gnt_q;
                gnt_id_d    = gnt_id_q;
                gnt_valid_d = gnt_valid_q;
                tenure_d    = (tenure_q >= HOLD_MAX_C) ? HOLD_MAX_C : (tenure_q + 8'd1);
            end
            default: begin
                gnt_d       = 8'h00;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                tenure_d    = 8'd0;
            end
        endcase
    end

    // Registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            tenure_q    <= 8'd0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            tenure_q    <= tenure_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_valid_q;
    assign preempt_o   = preempt_q;
    assign tenure_o    = tenure_q;

endmodule
